// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter that funnels completed functional-unit
// results onto a single common data bus (CDB).
// Each FU port owns a one-entry holding buffer. A buffer may be granted and
// refilled on the same edge, so a streaming FU sustains one result per cycle.
// Optional feature macro: CDB_FLUSH_EN adds a 'flush' input. While flush is
// high, all buffered results are discarded, the broadcast is suppressed and
// no new results are accepted.
module cdb_arbiter #(
  parameter int XLEN      = 32,
  parameter int TAG_WIDTH = 32,
  parameter int N_FU      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
`ifdef CDB_FLUSH_EN
  input  logic                      flush,
`endif
  input  logic [N_FU-1:0]           fu_valid,
  input  logic [N_FU*TAG_WIDTH-1:0] fu_rob_tag,
  input  logic [N_FU*XLEN-1:0]      fu_data,
  output logic [N_FU-1:0]           fu_ready,
  output logic                      cdb_valid,
  output logic [TAG_WIDTH-1:0]      cdb_rob_tag,
  output logic [XLEN-1:0]           cdb_data
);

  localparam int PTR_W = (N_FU > 1) ? $clog2(N_FU) : 1;

  logic [N_FU-1:0]      occ_q, occ_d;
  logic [TAG_WIDTH-1:0] tag_q  [N_FU];
  logic [TAG_WIDTH-1:0] tag_d  [N_FU];
  logic [XLEN-1:0]      data_q [N_FU];
  logic [XLEN-1:0]      data_d [N_FU];
  logic [PTR_W-1:0]     rr_q, rr_d;
  logic                 cdb_valid_q, cdb_valid_d;
  logic [TAG_WIDTH-1:0] cdb_tag_q, cdb_tag_d;
  logic [XLEN-1:0]      cdb_data_q, cdb_data_d;

  logic [N_FU-1:0]      grant_s;
  logic                 any_grant_s;
  logic [PTR_W-1:0]     gidx_s;
  logic [PTR_W:0]       sum_s;
  logic [PTR_W-1:0]     idx_s;
  logic [N_FU-1:0]      xfer_s;

  // Rotating-priority search: first occupied buffer at or after rr_q wins.
  always_comb begin
    grant_s     = '0;
    gidx_s      = '0;
    any_grant_s = 1'b0;
    sum_s       = '0;
    idx_s       = '0;
    for (int k = 0; k < N_FU; k++) begin
      sum_s = {1'b0, rr_q} + (PTR_W+1)'(k);
      if (sum_s >= (PTR_W+1)'(N_FU)) begin
        sum_s = sum_s - (PTR_W+1)'(N_FU);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[PTR_W-1:0];
      if (!any_grant_s && occ_q[idx_s]) begin
        grant_s[idx_s] = 1'b1;
        gidx_s         = idx_s;
        any_grant_s    = 1'b1;
      end else begin
        any_grant_s = any_grant_s;
      end
    end
  end

  // A port can take a result when its buffer is empty or is draining this cycle.
`ifdef CDB_FLUSH_EN
  assign fu_ready = flush ? '0 : (~occ_q | grant_s);
`else
  assign fu_ready = ~occ_q | grant_s;
`endif

  assign xfer_s = fu_valid & fu_ready;

  // Next-state: broadcast the granted buffer, then capture any new results.
  always_comb begin
    occ_d       = occ_q;
    tag_d       = tag_q;
    data_d      = data_q;
    rr_d        = rr_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;

    if (any_grant_s) begin
      cdb_valid_d   = 1'b1;
      cdb_tag_d     = tag_q[gidx_s];
      cdb_data_d    = data_q[gidx_s];
      occ_d[gidx_s] = 1'b0;
      rr_d          = (gidx_s == PTR_W'(N_FU-1)) ? '0 : gidx_s + PTR_W'(1);
    end else begin
      cdb_valid_d = 1'b0;
    end

    // A refill after the grant clear keeps a streaming buffer occupied.
    for (int i = 0; i < N_FU; i++) begin
      if (xfer_s[i]) begin
        occ_d[i]  = 1'b1;
        tag_d[i]  = fu_rob_tag[i*TAG_WIDTH +: TAG_WIDTH];
        data_d[i] = fu_data[i*XLEN +: XLEN];
      end else begin
        occ_d[i] = occ_d[i];
      end
    end

`ifdef CDB_FLUSH_EN
    // Flush discards everything in flight; the pointer and last bus value hold.
    if (flush) begin
      occ_d       = '0;
      rr_d        = rr_q;
      cdb_valid_d = 1'b0;
      cdb_tag_d   = cdb_tag_q;
      cdb_data_d  = cdb_data_q;
    end else begin
      rr_d = rr_d;
    end
`endif
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q       <= '0;
      rr_q        <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      for (int i = 0; i < N_FU; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      occ_q       <= occ_d;
      rr_q        <= rr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
    end
  end

  assign cdb_valid   = cdb_valid_q;
  assign cdb_rob_tag = cdb_tag_q;
  assign cdb_data    = cdb_data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (N_FU=4, XLEN=32, TAG_WIDTH=32).
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_cdb_arbiter;

  logic        clk;
  logic        reset;
`ifdef CDB_FLUSH_EN
  logic        flush;
`endif
  logic [3:0]   fu_valid;
  logic [127:0] fu_rob_tag;
  logic [127:0] fu_data;
  logic [3:0]   fu_ready;
  logic         cdb_valid;
  logic [31:0]  cdb_rob_tag;
  logic [31:0]  cdb_data;

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(.XLEN(32), .TAG_WIDTH(32), .N_FU(4)) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef CDB_FLUSH_EN
    .flush       (flush),
`endif
    .fu_valid    (fu_valid),
    .fu_rob_tag  (fu_rob_tag),
    .fu_data     (fu_data),
    .fu_ready    (fu_ready),
    .cdb_valid   (cdb_valid),
    .cdb_rob_tag (cdb_rob_tag),
    .cdb_data    (cdb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int port, input logic [31:0] tag, input logic [31:0] data);
    fu_rob_tag[port*32 +: 32] = tag;
    fu_data[port*32 +: 32]    = data;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    fu_valid   = 4'h0;
    fu_rob_tag = 128'h0;
    fu_data    = 128'h0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    logic [3:0]  rdy;
    logic [31:0] t0;
    logic [31:0] t2;
    logic [31:0] exp_tag;
`ifdef CDB_FLUSH_EN
    flush = 1'b0;
`endif
    reset      = 1'b0;
    fu_valid   = 4'h0;
    fu_rob_tag = 128'h0;
    fu_data    = 128'h0;
    #3;
    // Reset state, before any clock edge.
    chk("rst_ready", fu_ready, 4'hF);
    chk("rst_valid", cdb_valid, 1'b0);
    chk("rst_tag", cdb_rob_tag, 32'h0);
    chk("rst_data", cdb_data, 32'h0);
    do_reset();

    // Single result on FU1.
    fu_valid = 4'b0010;
    put(1, 32'd5, 32'hDEADBEEF);
    chk("single_ready", fu_ready[1], 1'b1);
    step();
    fu_valid = 4'h0;
    put(1, 32'd99, 32'h12345678);
    chk("single_k", cdb_valid, 1'b0);
    step();
    chk("single_valid", cdb_valid, 1'b1);
    chk("single_tag", cdb_rob_tag, 32'd5);
    chk("single_data", cdb_data, 32'hDEADBEEF);
    step();
    chk("single_drop", cdb_valid, 1'b0);
    chk("single_hold_tag", cdb_rob_tag, 32'd5);
    chk("single_hold_data", cdb_data, 32'hDEADBEEF);

    // Inputs with fu_valid low are ignored.
    for (int p = 0; p < 4; p++) put(p, 32'd77, 32'h77);
    step();
    step();
    chk("ignore_valid", cdb_valid, 1'b0);
    chk("ignore_tag", cdb_rob_tag, 32'd5);

    // Contention: all four from reset, tags 10..13.
    do_reset();
    fu_valid = 4'hF;
    for (int p = 0; p < 4; p++) put(p, 32'd10 + 32'(p), 32'h100 + 32'(p));
    step();
    fu_valid = 4'h0;
    chk("cont_ready0", fu_ready, 4'b0001);
    step();
    chk("cont_v0", cdb_valid, 1'b1);
    chk("cont_t0", cdb_rob_tag, 32'd10);
    chk("cont_ready1", fu_ready, 4'b0011);
    step();
    chk("cont_v1", cdb_valid, 1'b1);
    chk("cont_t1", cdb_rob_tag, 32'd11);
    chk("cont_d1", cdb_data, 32'h101);
    chk("cont_ready2", fu_ready, 4'b0111);
    step();
    chk("cont_v2", cdb_valid, 1'b1);
    chk("cont_t2", cdb_rob_tag, 32'd12);
    chk("cont_ready3", fu_ready, 4'b1111);
    step();
    chk("cont_v3", cdb_valid, 1'b1);
    chk("cont_t3", cdb_rob_tag, 32'd13);
    chk("cont_d3", cdb_data, 32'h103);
    step();
    chk("cont_end", cdb_valid, 1'b0);

    // Fairness: FU0 (tags 100..) and FU2 (tags 200..) always valid.
    do_reset();
    t0 = 32'd100;
    t2 = 32'd200;
    fu_valid = 4'b0101;
    for (int n = 0; n < 10; n++) begin
      put(0, t0, t0);
      put(2, t2, t2);
      rdy = fu_ready;
      if (n == 0) chk("fair_rdy0", rdy, 4'b1111);
      else if (n % 2 == 1) chk("fair_rdy_odd", rdy, 4'b1011);
      else chk("fair_rdy_even", rdy, 4'b1110);
      step();
      if (rdy[0]) t0 = t0 + 32'd1;
      if (rdy[2]) t2 = t2 + 32'd1;
      if (n == 0) begin
        chk("fair_first", cdb_valid, 1'b0);
      end else begin
        exp_tag = (n % 2 == 1) ? 32'd100 + 32'((n - 1) / 2) : 32'd200 + 32'((n - 1) / 2);
        chk("fair_valid", cdb_valid, 1'b1);
        chk("fair_tag", cdb_rob_tag, exp_tag);
      end
    end
    fu_valid = 4'h0;

    // Refill: FU3 streams 20,21,22.
    do_reset();
    fu_valid = 4'b1000;
    put(3, 32'd20, 32'hA20);
    chk("refill_rdy0", fu_ready[3], 1'b1);
    step();
    chk("refill_v0", cdb_valid, 1'b0);
    put(3, 32'd21, 32'hA21);
    chk("refill_rdy1", fu_ready[3], 1'b1);
    step();
    chk("refill_t20", cdb_rob_tag, 32'd20);
    chk("refill_v20", cdb_valid, 1'b1);
    put(3, 32'd22, 32'hA22);
    chk("refill_rdy2", fu_ready[3], 1'b1);
    step();
    fu_valid = 4'h0;
    chk("refill_t21", cdb_rob_tag, 32'd21);
    chk("refill_v21", cdb_valid, 1'b1);
    step();
    chk("refill_t22", cdb_rob_tag, 32'd22);
    chk("refill_d22", cdb_data, 32'hA22);
    chk("refill_v22", cdb_valid, 1'b1);
    step();
    chk("refill_end", cdb_valid, 1'b0);

    // Reset mid-broadcast with tags 30,31 still buffered.
    do_reset();
    fu_valid = 4'b0111;
    put(0, 32'd29, 32'h29);
    put(1, 32'd30, 32'h30);
    put(2, 32'd31, 32'h31);
    step();
    fu_valid = 4'h0;
    step();
    chk("rstmid_pre_v", cdb_valid, 1'b1);
    chk("rstmid_pre_t", cdb_rob_tag, 32'd29);
    #2;
    reset = 1'b0;
    #1;
    chk("rstmid_v", cdb_valid, 1'b0);
    chk("rstmid_tag", cdb_rob_tag, 32'd0);
    chk("rstmid_data", cdb_data, 32'd0);
    chk("rstmid_ready", fu_ready, 4'hF);
    step();
    reset = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      chk("rstmid_after", cdb_valid, 1'b0);
    end

`ifdef CDB_FLUSH_EN
    // Flush with buffers occupied; pointer must hold at 1.
    do_reset();
    fu_valid = 4'b0111;
    put(0, 32'd40, 32'h40);
    put(1, 32'd41, 32'h41);
    put(2, 32'd42, 32'h42);
    step();
    fu_valid = 4'h0;
    step();
    chk("flush_pre_t", cdb_rob_tag, 32'd40);
    flush = 1'b1;
    #1;
    chk("flush_ready", fu_ready, 4'h0);
    step();
    flush = 1'b0;
    chk("flush_v0", cdb_valid, 1'b0);
    step();
    chk("flush_v1", cdb_valid, 1'b0);
    step();
    chk("flush_v2", cdb_valid, 1'b0);
    fu_valid = 4'b0110;
    put(1, 32'd51, 32'h51);
    put(2, 32'd52, 32'h52);
    step();
    fu_valid = 4'h0;
    step();
    chk("flush_rr_t0", cdb_rob_tag, 32'd51);
    step();
    chk("flush_rr_t1", cdb_rob_tag, 32'd52);
    step();
    chk("flush_end", cdb_valid, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter XLEN, default 32, width of data broadcast on the common data bus.
REQ-002 Parameter TAG_WIDTH, default 32, width of the ROB tag.
REQ-003 Parameter N_FU, default 4, number of functional-unit (FU) result ports; legal range 2..8.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 fu_valid  input  N_FU  bit i set: FU i presents a completed result.
REQ-007 fu_rob_tag  input  N_FU*TAG_WIDTH  ROB tag of FU i at bits [i*TAG_WIDTH +: TAG_WIDTH].
REQ-008 fu_data  input  N_FU*XLEN  result of FU i at bits [i*XLEN +: XLEN].
REQ-009 fu_ready  output  N_FU  bit i set: port i accepts a result this cycle.
REQ-010 cdb_valid  output  1  broadcast qualifier seen by reservation stations and ROB.
REQ-011 cdb_rob_tag  output  TAG_WIDTH  tag being broadcast.
REQ-012 cdb_data  output  XLEN  value being broadcast.
REQ-013 flush  input  1  present only when CDB_FLUSH_EN is defined (see Configuration).

Function
REQ-014 Each port has a one-entry holding buffer (occupied bit, tag, data); a transfer occurs when fu_valid[i] && fu_ready[i] at posedge clk.
REQ-015 fu_ready[i] = !occupied[i] || grant[i]; same-cycle grant and refill of one buffer is legal and does not drop or duplicate results.
REQ-016 Grant is combinational, one-hot or zero, among occupied buffers only; no buffer occupied -> no grant.
REQ-017 Round-robin: priority starts at rr_ptr and ascends modulo N_FU; after a grant to port g, rr_ptr <= (g+1) mod N_FU; with no grant, rr_ptr holds.
REQ-018 On grant to g, cdb_valid <= 1, cdb_rob_tag <= buffered tag g, cdb_data <= buffered data g, and occupied[g] clears unless refilled per REQ-015.
REQ-019 No grant -> cdb_valid <= 0; cdb_rob_tag and cdb_data hold their previous values.
REQ-020 Latency: a result accepted at edge k is broadcast for exactly one cycle after edge k+1 at the earliest; with contention it waits at most N_FU-1 additional cycles (starvation-free).
REQ-021 Each accepted result is broadcast exactly once; the CDB carries at most one result per cycle.
REQ-022 Sustained throughput is one broadcast per cycle whenever any buffer is occupied.
REQ-023 fu_rob_tag/fu_data are sampled only on a transfer; values with fu_valid low are ignored.

Reset
REQ-024 While reset is low (asynchronous assertion): occupied = 0 all ports, rr_ptr = 0, cdb_valid = 0, cdb_rob_tag = 0, cdb_data = 0, buffered tags/data = 0.
REQ-025 During reset fu_ready reads all ones (all buffers empty), but no transfer is captured until the first posedge clk after reset deasserts.
REQ-026 Reset mid-broadcast drops cdb_valid immediately and discards all buffered results.

Configuration
REQ-027 Macro CDB_FLUSH_EN: when defined, port flush exists; flush high at posedge clk clears all occupied bits, sets cdb_valid <= 0, holds rr_ptr, and fu_ready is forced to 0 while flush is high, so nothing is accepted.
REQ-028 Flush has priority over grant and transfer in the same cycle; the granted result is not broadcast.
REQ-029 Without CDB_FLUSH_EN: no flush port, no flush logic; behaviour is exactly REQ-014..REQ-026.

Verification (N_FU=4, XLEN=32, TAG_WIDTH=32)
REQ-030 Single: FU1 presents tag 5, data 0xDEADBEEF for one cycle -> cdb_valid high for exactly one cycle, 2 edges after acceptance, tag 5, data 0xDEADBEEF.
REQ-031 Contention: all four FUs present tags 10..13 in the same cycle from reset -> broadcasts occur on 4 consecutive cycles in tag order 10,11,12,13; fu_ready[1..3] low until each is granted.
REQ-032 Fairness: FU0 and FU2 hold fu_valid high continuously with incrementing tags -> CDB alternates FU0/FU2 every cycle, no gaps, no repeated tag.
REQ-033 Refill: FU3 streams tags 20,21,22 back-to-back with no competition -> fu_ready[3] stays high; CDB carries 20,21,22 on 3 consecutive cycles.
REQ-034 Reset: assert reset while buffers hold tags 30,31 and cdb_valid=1 -> cdb_valid falls without clk, and tags 30,31 are never broadcast after release.
REQ-035 Flush (CDB_FLUSH_EN): flush high for one cycle with 3 buffers occupied -> no further cdb_valid until new results arrive; rr_ptr is unchanged.
